ring_buffer: RTL and testbench

- Circular sample store between the SPI ADC front end and the trigger/FFT stage of the acoustics FPGA.
- Captures one 10-bit sample per Input_Data_Ready strobe.
- On a Send_Frame request from the trigger block, streams out the most recent FRAME_LEN samples, oldest first, one per clock.
- Flags lost (overwritten) samples on RAM_Overflow.

---
 rtl/ring_buffer_if.sv | 39 +++
 rtl/ring_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_ring_buffer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_buffer_if.sv
// Sample/frame port bundle between the SPI ADC front end, the trigger block
// and the ring buffer. The producer side (ADC + trigger) uses the master
// modport; the ring buffer uses the slave modport.
//
// Handshake semantics:
//   Input_Data_Ready is a level strobe that may stay high for many clocks;
//   only its rising edge captures Input_Data, which must be stable while the
//   strobe is high. Send_Frame likewise counts only on its rising edge.
//   Output_Valid has no ready/backpressure: the consumer must take
//   Output_Data on every clock where Output_Valid is high. Frame samples come
//   out on consecutive clocks, oldest first.
interface ring_buffer_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] Input_Data;
  logic              Input_Data_Ready;
  logic              Send_Frame;
  logic [DATA_W-1:0] Output_Data;
  logic              Output_Valid;
  logic              RAM_Overflow;

  modport master (
    output Input_Data,
    output Input_Data_Ready,
    output Send_Frame,
    input  Output_Data,
    input  Output_Valid,
    input  RAM_Overflow
  );

  modport slave (
    input  Input_Data,
    input  Input_Data_Ready,
    input  Send_Frame,
    output Output_Data,
    output Output_Valid,
    output RAM_Overflow
  );
endinterface

// File: rtl/ring_buffer.sv
// Circular sample store between the SPI ADC front end and the trigger/FFT
// stage. One sample is written per rising edge of Input_Data_Ready; a rising
// edge of Send_Frame streams the most recent FRAME_LEN samples, oldest first,
// one per clock. Overwriting unread data raises the sticky RAM_Overflow flag.
//
// Readout timing, with the request accepted at clock edge T:
//   edge T        : read pointer loaded, FSM enters S_READ
//   edges T+1..   : one synchronous RAM read per clock into r_ram_q
//   edges T+2..   : r_ram_q copied into the output register
// so Output_Valid is high for cycles T+2 .. T+FRAME_LEN+1.
//
// FRAME_LEN must not exceed DEPTH/2 and DEPTH must be a power of two. With
// writes at most every second clock, writes during a readout land outside
// the addresses being read, so no collision handling is needed.
module ring_buffer #(
  parameter int DATA_W    = 10,
  parameter int DEPTH     = 512,
  parameter int FRAME_LEN = 256
) (
  input  logic                     clk,
  input  logic                     reset_b,   // active-high synchronous reset
  ring_buffer_if.slave             bus,
  output logic [1:0]               o_dbg_state,
  output logic [$clog2(DEPTH):0]   o_dbg_count,
  output logic [$clog2(DEPTH)-1:0] o_dbg_wr_ptr
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_LEN);
  localparam logic [ADDR_W-1:0] FRAME_OFS = ADDR_W'(FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST_RD   = ADDR_W'(FRAME_LEN - 1);

  // S_IDLE : no frame in progress, requests may be accepted
  // S_READ : issuing FRAME_LEN sequential RAM reads
  // S_DRAIN: last read in flight to the output register
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Edge detectors
  logic r_rdy_q;
  logic r_sf_q;

  // Write side
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  // Read side
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [DATA_W-1:0] r_ram_q;
  logic              r_rd_vld;
  logic [DATA_W-1:0] r_out;
  logic              r_out_vld;

  // Storage; never reset
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Decoded events for this clock
  logic w_write;
  logic w_req;
  logic w_accept;
  logic w_full;
  logic w_rd_issue;

  assign w_write  = bus.Input_Data_Ready & ~r_rdy_q;
  assign w_req    = bus.Send_Frame & ~r_sf_q;
  assign w_full   = (r_count == CNT_FULL);
  assign w_accept = w_req && (r_state == S_IDLE) && (r_count >= CNT_FRAME);

  // Register the strobes so that only their rising edges act
  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_rdy_q <= 1'b0;
      r_sf_q  <= 1'b0;
    end else begin
      r_rdy_q <= bus.Input_Data_Ready;
      r_sf_q  <= bus.Send_Frame;
    end
  end

  // Readout FSM state register
  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Readout FSM next state and read-issue decode
  always_comb begin
    w_state_nxt = r_state;
    w_rd_issue  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_rd_issue = 1'b1;
        if (r_rd_cnt == LAST_RD) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Write pointer, fill count and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      // An accepted frame consumes all buffered samples; a same-cycle write
      // is the first sample of the next frame.
      if (w_accept) begin
        r_count <= w_write ? CNT_W'(1) : '0;
      end else if (w_write && !w_full) begin
        r_count <= r_count + 1'b1;
      end

      // Losing a sample outranks the clear from a same-cycle accept.
      if (w_write && w_full) begin
        r_overflow <= 1'b1;
      end else if (w_accept) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Sample RAM write port; blocked while reset is asserted
  always_ff @(posedge clk) begin
    if (w_write && !reset_b) begin
      r_mem[r_wr_ptr] <= bus.Input_Data;
    end
  end

  // Read address generation; start is FRAME_LEN behind the pre-write pointer
  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_rd_addr <= '0;
      r_rd_cnt  <= '0;
    end else if (w_accept) begin
      r_rd_addr <= r_wr_ptr - FRAME_OFS;
      r_rd_cnt  <= '0;
    end else if (w_rd_issue) begin
      r_rd_addr <= r_rd_addr + 1'b1;
      r_rd_cnt  <= r_rd_cnt + 1'b1;
    end
  end

  // Synchronous RAM read port
  always_ff @(posedge clk) begin
    if (w_rd_issue) begin
      r_ram_q <= r_mem[r_rd_addr];
    end
  end

  // Output register; data holds its last sample once the frame ends
  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_rd_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else begin
      r_rd_vld  <= w_rd_issue;
      r_out_vld <= r_rd_vld;
      if (r_rd_vld) begin
        r_out <= r_ram_q;
      end
    end
  end

  assign bus.Output_Data  = r_out;
  assign bus.Output_Valid = r_out_vld;
  assign bus.RAM_Overflow = r_overflow;

  assign o_dbg_state  = r_state;
  assign o_dbg_count  = r_count;
  assign o_dbg_wr_ptr = r_wr_ptr;

endmodule

// File: tb/tb_ring_buffer.sv
// Directed bench for ring_buffer. Written samples are kept in a history
// queue; each expected-accepted frame request pushes the last FRAME_LEN
// samples into exp_q, and a negedge monitor pops and compares every
// Output_Valid beat. Any beat with nothing expected is flagged.
module tb_ring_buffer;

  localparam int DATA_W    = 10;
  localparam int DEPTH     = 512;
  localparam int FRAME_LEN = 256;
  localparam int ADDR_W    = $clog2(DEPTH);

  logic clk;
  logic reset_b;
  logic [1:0]        dbg_state;
  logic [ADDR_W:0]   dbg_count;
  logic [ADDR_W-1:0] dbg_wr_ptr;

  ring_buffer_if #(.DATA_W(DATA_W)) bus ();

  ring_buffer #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count),
    .o_dbg_wr_ptr(dbg_wr_ptr)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] hist[$];
  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int first_v_cyc = 0;
  int last_v_cyc  = 0;
  int req_cyc = 0;
  logic prev_v = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every valid beat must match the next expected sample
  always @(negedge clk) begin
    if (!reset_b) begin
      if (bus.Output_Valid) begin
        n_out++;
        if (!prev_v) first_v_cyc = cyc;
        last_v_cyc = cyc;
        check("stray_valid", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("frame_data", 32'(bus.Output_Data), 32'(exp_q.pop_front()));
      end else if (prev_v) begin
        check("frame_gap", 32'(exp_q.size()), 32'd0);
      end
    end
    prev_v = bus.Output_Valid;
  end

  // ---------------- driver tasks ----------------
  // One sample: strobe high for 'hi' clocks, period 'per' clocks in total.
  task automatic strobe(input logic [DATA_W-1:0] d, input int hi, input int per);
    @(posedge clk); #1;
    bus.Input_Data       = d;
    bus.Input_Data_Ready = 1'b1;
    hist.push_back(d);
    if (hist.size() > FRAME_LEN) void'(hist.pop_front());
    repeat (hi) @(posedge clk);
    #1 bus.Input_Data_Ready = 1'b0;
    repeat (per - hi - 1) @(posedge clk);
  endtask

  task automatic strobe_rand(input int n, input int hi, input int per);
    for (int i = 0; i < n; i++) strobe(DATA_W'($urandom_range(0, (1 << DATA_W) - 1)), hi, per);
  endtask

  task automatic push_frame();
    for (int k = 0; k < FRAME_LEN; k++) exp_q.push_back(hist[k]);
  endtask

  // Two-clock Send_Frame pulse; the rising edge is sampled at cycle req_cyc.
  task automatic request(input bit accept);
    @(posedge clk); #1;
    bus.Send_Frame = 1'b1;
    req_cyc = cyc + 1;
    if (accept) push_frame();
    @(posedge clk); #1;
    bus.Send_Frame = 1'b0;
  endtask

  // One-clock reset pulse; called in the #1-after-posedge phase.
  task automatic pulse_reset();
    reset_b = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    reset_b = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || bus.Output_Valid) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Watchdog: only fires if something hangs
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    int guard;
    reset_b              = 1'b1;
    bus.Input_Data       = '0;
    bus.Input_Data_Ready = 1'b0;
    bus.Send_Frame       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data",  32'(bus.Output_Data),  32'd0);
    check("rst_out_valid", 32'(bus.Output_Valid), 32'd0);
    check("rst_overflow",  32'(bus.RAM_Overflow), 32'd0);
    check("rst_count",     32'(dbg_count),        32'd0);
    check("rst_wr_ptr",    32'(dbg_wr_ptr),       32'd0);
    check("rst_state",     32'(dbg_state),        32'd0);
    reset_b = 1'b0;

    // 1: 256 long strobes with data 0..255, then one frame
    n0 = n_out;
    for (int i = 0; i < 256; i++) strobe(DATA_W'(i), 14, 20);
    check("t1_count", 32'(dbg_count), 32'd256);
    request(1);
    wait_drain("t1_drain");
    check("t1_latency", 32'(first_v_cyc), 32'(req_cyc + 2));
    check("t1_run_len", 32'(last_v_cyc - first_v_cyc + 1), 32'(FRAME_LEN));
    check("t1_beats",   32'(n_out - n0), 32'(FRAME_LEN));
    check("t1_overflow", 32'(bus.RAM_Overflow), 32'd0);
    check("t1_last_hold", 32'(bus.Output_Data), 32'h0FF);
    check("t1_idle", 32'(dbg_state), 32'd0);

    // 2: request with too few samples is dropped, count is kept
    n0 = n_out;
    for (int i = 0; i < 100; i++) strobe(DATA_W'(32'h100 + i), 4, 8);
    check("t2_count100", 32'(dbg_count), 32'd100);
    request(0);
    repeat (20) @(posedge clk);
    #1;
    check("t2_ignored", 32'(n_out - n0), 32'd0);
    for (int i = 0; i < 256; i++) strobe(DATA_W'(32'h200 + i), 4, 8);
    check("t2_count356", 32'(dbg_count), 32'd356);
    request(1);
    wait_drain("t2_drain");
    check("t2_beats", 32'(n_out - n0), 32'(FRAME_LEN));

    // 3: overflow after 513 samples, frame = 344..599, accept clears flag
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      strobe(DATA_W'(i), 4, 8);
      if (i == 511) check("t3_ovf_at512", 32'(bus.RAM_Overflow), 32'd0);
      if (i == 512) check("t3_ovf_at513", 32'(bus.RAM_Overflow), 32'd1);
    end
    check("t3_count_sat", 32'(dbg_count), 32'(DEPTH));
    check("t3_wr_ptr", 32'(dbg_wr_ptr), 32'(600 % DEPTH));
    check("t3_hist_first", 32'(hist[0]), 32'd344);
    request(1);
    check("t3_ovf_clear", 32'(bus.RAM_Overflow), 32'd0);
    wait_drain("t3_drain");

    // 4: second request during readout with continuous strobes
    n0 = n_out;
    strobe_rand(256, 2, 4);
    request(1);
    fork
      strobe_rand(300, 1, 4);
      begin
        repeat (40) @(posedge clk);
        request(0);
      end
    join
    wait_drain("t4_drain1");
    check("t4_count", 32'(dbg_count), 32'd300);
    request(1);
    wait_drain("t4_drain2");
    check("t4_beats", 32'(n_out - n0), 32'(2 * FRAME_LEN));

    // 5: long Input_Data_Ready gives one write; long Send_Frame one frame
    pulse_reset();
    @(posedge clk); #1;
    bus.Input_Data       = DATA_W'(32'h3AA);
    bus.Input_Data_Ready = 1'b1;
    hist.push_back(DATA_W'(32'h3AA));
    if (hist.size() > FRAME_LEN) void'(hist.pop_front());
    repeat (50) @(posedge clk);
    #1 bus.Input_Data_Ready = 1'b0;
    check("t5_one_write", 32'(dbg_count), 32'd1);
    strobe_rand(255, 2, 6);
    check("t5_count256", 32'(dbg_count), 32'd256);
    n0 = n_out;
    @(posedge clk); #1;
    bus.Send_Frame = 1'b1;
    push_frame();
    strobe_rand(300, 2, 4);
    check("t5_beats", 32'(n_out - n0), 32'(FRAME_LEN));
    check("t5_count300", 32'(dbg_count), 32'd300);
    bus.Send_Frame = 1'b0;
    wait_drain("t5_drain");

    // 6: reset in the middle of a readout aborts it
    pulse_reset();
    strobe_rand(256, 2, 6);
    n0 = n_out;
    request(1);
    guard = 0;
    while ((n_out - n0) < 100 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("t6_reached100", 32'((n_out - n0) >= 100), 32'd1);
    pulse_reset();
    check("t6_valid_off", 32'(bus.Output_Valid), 32'd0);
    check("t6_data_zero", 32'(bus.Output_Data),  32'd0);
    check("t6_count_zero", 32'(dbg_count),       32'd0);
    check("t6_state_idle", 32'(dbg_state),       32'd0);
    n0 = n_out;
    strobe_rand(100, 2, 6);
    request(0);
    repeat (20) @(posedge clk);
    #1;
    check("t6_ignored", 32'(n_out - n0), 32'd0);
    strobe_rand(156, 2, 6);
    request(1);
    wait_drain("t6_drain");
    check("t6_beats", 32'(n_out - n0), 32'(FRAME_LEN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
